uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_bus_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_pkg.sv
// Shared types and defaults for the UART transmit-side bus arbiter.
package uart_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arbState_t;

    localparam int          NREQ_DEFAULT    = 4;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// First set bit of Req at or after Ptr, wrapping from NREQ-1 back to 0.
module rr_pick
    import uart_bus_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] Req,
    input  logic [PW-1:0]   Ptr,
    output logic [NREQ-1:0] Winner,
    output logic            Valid
);

    logic [PW-1:0] idx;

    always_comb begin
        Winner = '0;
        Valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(Ptr) + k) % NREQ);
            if (!Valid && Req[idx]) begin
                Winner[idx] = 1'b1;
                Valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters,
// with an idle-grant watchdog that revokes and blocks a stalled owner.
//
// state | meaning
// IDLE  | no owner; round-robin search over eligible Apply bits
// GRANT | owner drives UARTSend/UARTDatLock; watchdog running
// DRAIN | owner released while UART busy; Grant held until UARTAvl
// GAP   | one dead cycle with Grant=0; pointer moves past the last owner
module uart_tx_arbiter
    import uart_bus_pkg::*;
#(
    parameter int          NREQ    = NREQ_DEFAULT,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Apply,
    input  logic [8*NREQ-1:0] ReqSend,
    input  logic [NREQ-1:0]   ReqLock,
    input  logic              UARTAvl,
    output logic [7:0]        UARTSend,
    output logic              UARTDatLock,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   ReqAvl,
    output logic [7:0]        ByteCnt,
    output logic              TimeoutErr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arbState_t       state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pickIdx;
    logic [PW-1:0]   nextPtr;
    logic [NREQ-1:0] blockMask;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pickOneHot;
    logic            pickValid;
    logic            lockPrev;
    logic            ownApply;
    logic            ownLock;
    logic            lockEdge;
    logic [15:0]     wdog;

    // A requester revoked by the watchdog stays out until it drops Apply.
    assign eligible = Apply & ~blockMask;

    rr_pick #(.NREQ(NREQ)) uPick (
        .Req    (eligible),
        .Ptr    (ptr),
        .Winner (pickOneHot),
        .Valid  (pickValid)
    );

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pickOneHot[i]) pickIdx = PW'(i);
    end

    assign nextPtr     = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign ownApply    = Apply[owner];
    assign ownLock     = ReqLock[owner];
    assign lockEdge    = ownLock & ~lockPrev;
    assign UARTSend    = (state == GRANT) ? ReqSend[{owner, 3'b000} +: 8] : 8'h00;
    assign UARTDatLock = (state == GRANT) & ownLock;
    assign ReqAvl      = Grant & {NREQ{UARTAvl}};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            wdog       <= '0;
            ByteCnt    <= '0;
            Grant      <= '0;
            TimeoutErr <= 1'b0;
            blockMask  <= '0;
            lockPrev   <= 1'b0;
        end else begin
            TimeoutErr <= 1'b0;
            blockMask  <= blockMask & Apply;
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        state    <= GRANT;
                        owner    <= pickIdx;
                        Grant    <= pickOneHot;
                        ByteCnt  <= '0;
                        wdog     <= TIMEOUT;
                        lockPrev <= 1'b0;
                    end
                end
                GRANT: begin
                    lockPrev <= ownLock;
                    if (lockEdge) ByteCnt <= satInc8(ByteCnt);
                    if (!ownApply) begin
                        if (UARTAvl) begin
                            state <= GAP;
                            Grant <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (lockEdge) begin
                        wdog <= TIMEOUT;
                    end else if (UARTAvl) begin
                        // Down-count of idle-but-ready cycles; fires on the TIMEOUT-th one.
                        if (wdog <= 16'd1) begin
                            state      <= GAP;
                            Grant      <= '0;
                            TimeoutErr <= 1'b1;
                            blockMask  <= (blockMask & Apply) | Grant;
                        end else begin
                            wdog <= wdog - 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (UARTAvl) begin
                        state <= GAP;
                        Grant <= '0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    ptr   <= nextPtr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int          NREQ = 4;
    localparam logic [15:0] TMO  = 16'd20;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [NREQ-1:0]   Apply;
    logic [8*NREQ-1:0] ReqSend;
    logic [NREQ-1:0]   ReqLock;
    logic              UARTAvl;
    logic [7:0]        UARTSend;
    logic              UARTDatLock;
    logic [NREQ-1:0]   Grant;
    logic [NREQ-1:0]   ReqAvl;
    logic [7:0]        ByteCnt;
    logic              TimeoutErr;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Apply       (Apply),
        .ReqSend     (ReqSend),
        .ReqLock     (ReqLock),
        .UARTAvl     (UARTAvl),
        .UARTSend    (UARTSend),
        .UARTDatLock (UARTDatLock),
        .Grant       (Grant),
        .ReqAvl      (ReqAvl),
        .ByteCnt     (ByteCnt),
        .TimeoutErr  (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic [7:0]      byteCnt;
        logic            tmo;
        logic [7:0]      send;
        logic            datLock;
        logic [NREQ-1:0] reqAvl;
    } expect_t;

    expect_t expQ[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, and what phase the ownership is in.
    int              mOwner  = -1;
    int              mPtr    = 0;
    bit              mGap    = 1'b0;
    bit              mDrain  = 1'b0;
    int              mIdle   = 0;
    int              mBytes  = 0;
    bit [NREQ-1:0]   mBanned = '0;
    bit              mPrevLk = 1'b0;
    bit              mTmo    = 1'b0;

    task automatic modelStep();
        int c;
        bit edgeSeen;
        mTmo = 1'b0;
        if (Rst) begin
            mOwner = -1; mPtr = 0; mGap = 0; mDrain = 0;
            mIdle = 0; mBytes = 0; mBanned = '0; mPrevLk = 0;
            return;
        end
        mBanned = mBanned & Apply;
        if (mGap) begin
            mGap   = 0;
            mPtr   = (mOwner + 1) % NREQ;
            mOwner = -1;
        end else if (mOwner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (mPtr + k) % NREQ;
                if (Apply[c] && !mBanned[c]) begin
                    mOwner = c; mBytes = 0; mIdle = 0; mPrevLk = 0;
                    break;
                end
            end
        end else if (mDrain) begin
            if (UARTAvl) begin
                mDrain = 0;
                mGap   = 1;
            end
        end else begin
            edgeSeen = ReqLock[mOwner] && !mPrevLk;
            mPrevLk  = ReqLock[mOwner];
            if (edgeSeen && mBytes < 255) mBytes++;
            if (!Apply[mOwner]) begin
                if (UARTAvl) mGap = 1;
                else         mDrain = 1;
            end else if (edgeSeen) begin
                mIdle = 0;
            end else if (UARTAvl) begin
                mIdle++;
                if (mIdle == int'(TMO)) begin
                    mTmo = 1;
                    mBanned[mOwner] = 1'b1;
                    mGap = 1;
                end
            end
        end
    endtask

    function automatic expect_t modelOut();
        expect_t e;
        bit active;
        bit driving;
        active    = (mOwner >= 0) && !mGap;
        driving   = active && !mDrain;
        e.grant   = active ? (NREQ'(1) << mOwner) : '0;
        e.byteCnt = 8'(mBytes);
        e.tmo     = mTmo;
        e.send    = driving ? ReqSend[8*mOwner +: 8] : 8'h00;
        e.datLock = driving && ReqLock[mOwner];
        e.reqAvl  = e.grant & {NREQ{UARTAvl}};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int pOn, input int pOff, input int pLock, input int pAvl, input int pRst);
        logic [NREQ-1:0] a;
        logic [NREQ-1:0] l;
        a = Apply;
        for (int i = 0; i < NREQ; i++) begin
            if (a[i]) begin
                if ($urandom_range(99) < pOff) a[i] = 1'b0;
            end else if ($urandom_range(99) < pOn) begin
                a[i] = 1'b1;
            end
            l[i] = ($urandom_range(99) < pLock);
        end
        Apply   = a;
        ReqLock = l;
        ReqSend = $urandom;
        UARTAvl = ($urandom_range(99) < pAvl);
        Rst     = ($urandom_range(999) < pRst);
    endtask

    task automatic cycle(input int pOn, input int pOff, input int pLock, input int pAvl, input int pRst);
        @(negedge Clk);
        drive(pOn, pOff, pLock, pAvl, pRst);
        modelStep();
        expQ.push_back(modelOut());
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("Grant",       32'(Grant),       32'(e.grant));
                chk("ByteCnt",     32'(ByteCnt),     32'(e.byteCnt));
                chk("TimeoutErr",  32'(TimeoutErr),  32'(e.tmo));
                chk("UARTSend",    32'(UARTSend),    32'(e.send));
                chk("UARTDatLock", 32'(UARTDatLock), 32'(e.datLock));
                chk("ReqAvl",      32'(ReqAvl),      32'(e.reqAvl));
            end
        end
    end

    initial begin
        Rst     = 1'b1;
        Apply   = '0;
        ReqLock = '0;
        ReqSend = '0;
        UARTAvl = 1'b0;
        for (int n = 0; n < 3; n++)    cycle(0, 0, 0, 50, 1000);
        for (int n = 0; n < 3000; n++) cycle(20, 8, 40, 70, 3);
        for (int n = 0; n < 1500; n++) cycle(25, 10, 40, 15, 2);
        for (int n = 0; n < 1500; n++) cycle(30, 3, 0, 95, 1);
        for (int n = 0; n < 1500; n++) cycle(100, 0, 50, 60, 0);
        for (int n = 0; n < 500; n++)  cycle(40, 15, 30, 50, 10);
        @(posedge Clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
